scr1_dmem_accel_router: RTL and testbench



---
 rtl/scr1_dmem_accel_router.sv | 203 ++++++++++++++++++++
 tb/tb_scr1_dmem_accel_router.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_accel_router.sv
// Routes core data-memory requests to the accelerator register window, to data memory, or to a
// local error responder. Optional watchdog enabled by SCR1_DMEM_ROUTER_TIMEOUT_EN.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_router_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_accel_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] ACCEL_BASE = 32'hF000_0000,
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] ACCEL_MASK = 32'hFFFF_FFE0,
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] MEM_BASE   = 32'h0000_0000,
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] MEM_MASK   = 32'hFFF0_0000
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // core side
  input  logic                           core_req,
  output logic                           core_req_ack,
  input  type_scr1_mem_cmd_e             core_cmd,
  input  type_scr1_mem_width_e           core_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]   core_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]   core_wdata,
  output logic [`SCR1_DMEM_DWIDTH-1:0]   core_rdata,
  output type_scr1_mem_resp_e            core_resp,
  // accelerator side
  output logic                           accel_req,
  input  logic                           accel_req_ack,
  output type_scr1_mem_cmd_e             accel_cmd,
  output type_scr1_mem_width_e           accel_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0]   accel_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0]   accel_wdata,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]   accel_rdata,
  input  type_scr1_mem_resp_e            accel_resp,
  // memory side
  output logic                           mem_req,
  input  logic                           mem_req_ack,
  output type_scr1_mem_cmd_e             mem_cmd,
  output type_scr1_mem_width_e           mem_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0]   mem_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0]   mem_wdata,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]   mem_rdata,
  input  type_scr1_mem_resp_e            mem_resp
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
  ,
  output logic                           timeout_flag
`endif
);

  localparam int unsigned DW = `SCR1_DMEM_DWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ACCEL = 2'd1,
    ST_WAIT_MEM   = 2'd2,
    ST_ERR        = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   sel_accel, sel_mem;
  logic   timeout_c;

  // Address decode; the accelerator window takes priority on overlap.
  always_comb begin
    sel_accel = ((core_addr & ACCEL_MASK) == ACCEL_BASE);
    sel_mem   = !sel_accel && ((core_addr & MEM_MASK) == MEM_BASE);
  end

  assign accel_cmd   = core_cmd;
  assign accel_width = core_width;
  assign accel_addr  = core_addr;
  assign accel_wdata = core_wdata;
  assign mem_cmd     = core_cmd;
  assign mem_width   = core_width;
  assign mem_addr    = core_addr;
  assign mem_wdata   = core_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req && core_req_ack) begin
          if (sel_accel)    state_d = ST_WAIT_ACCEL;
          else if (sel_mem) state_d = ST_WAIT_MEM;
          else              state_d = ST_ERR;
        end
      end
      ST_WAIT_ACCEL: if (accel_resp != SCR1_MEM_RESP_NOTRDY || timeout_c) state_d = ST_IDLE;
      ST_WAIT_MEM:   if (mem_resp != SCR1_MEM_RESP_NOTRDY || timeout_c)   state_d = ST_IDLE;
      ST_ERR:        state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Handshake and response muxing; everything held quiet while reset is asserted.
  always_comb begin
    accel_req    = 1'b0;
    mem_req      = 1'b0;
    core_req_ack = 1'b0;
    core_resp    = SCR1_MEM_RESP_NOTRDY;
    core_rdata   = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          accel_req = core_req && sel_accel;
          mem_req   = core_req && sel_mem;
          if (sel_accel)    core_req_ack = accel_req_ack;
          else if (sel_mem) core_req_ack = mem_req_ack;
          else              core_req_ack = 1'b1;
        end
        ST_WAIT_ACCEL: begin
          if (timeout_c) begin
            core_resp = SCR1_MEM_RESP_RDY_ER;
          end else begin
            core_resp  = accel_resp;
            core_rdata = accel_rdata;
          end
        end
        ST_WAIT_MEM: begin
          if (timeout_c) begin
            core_resp = SCR1_MEM_RESP_RDY_ER;
          end else begin
            core_resp  = mem_resp;
            core_rdata = mem_rdata;
          end
        end
        ST_ERR: begin
          core_resp  = SCR1_MEM_RESP_RDY_ER;
          core_rdata = DW'(0);
        end
        default: ;
      endcase
    end
  end

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
  localparam int unsigned CntW = 16;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic            pending_c;

  // Watchdog: counts NOTRDY cycles of the owning target; fires when the count would reach the limit.
  always_comb begin
    pending_c = ((state_q == ST_WAIT_ACCEL) && (accel_resp == SCR1_MEM_RESP_NOTRDY)) ||
                ((state_q == ST_WAIT_MEM)   && (mem_resp   == SCR1_MEM_RESP_NOTRDY));
    timeout_c = pending_c && ((17'(cnt_q) + 17'd1) == 17'(TIMEOUT_CYCLES));
    cnt_d     = '0;
    if (pending_c && !timeout_c) cnt_d = cnt_q + CntW'(1);
    flag_d    = flag_q || timeout_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_flag = flag_q;
`else
  assign timeout_c = 1'b0;
`endif

endmodule

// File: tb/tb_scr1_dmem_accel_router.sv
// Randomized self-checking bench for scr1_dmem_accel_router; the watchdog section is built
// only when SCR1_DMEM_ROUTER_TIMEOUT_EN is defined.

module tb_scr1_dmem_accel_router;
  import scr1_dmem_router_pkg::*;

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
  localparam int MaxWaits = 2;
`else
  localparam int MaxWaits = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 core_req, core_req_ack;
  type_scr1_mem_cmd_e   core_cmd;
  type_scr1_mem_width_e core_width;
  logic [31:0]          core_addr, core_wdata, core_rdata;
  type_scr1_mem_resp_e  core_resp;
  logic                 accel_req, accel_req_ack;
  type_scr1_mem_cmd_e   accel_cmd;
  type_scr1_mem_width_e accel_width;
  logic [31:0]          accel_addr, accel_wdata, accel_rdata;
  type_scr1_mem_resp_e  accel_resp;
  logic                 mem_req, mem_req_ack;
  type_scr1_mem_cmd_e   mem_cmd;
  type_scr1_mem_width_e mem_width;
  logic [31:0]          mem_addr, mem_wdata, mem_rdata;
  type_scr1_mem_resp_e  mem_resp;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
  logic                 timeout_flag;
`endif

  int total = 0;
  int bad   = 0;

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
  scr1_dmem_accel_router #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .accel_req(accel_req), .accel_req_ack(accel_req_ack), .accel_cmd(accel_cmd),
    .accel_width(accel_width), .accel_addr(accel_addr), .accel_wdata(accel_wdata),
    .accel_rdata(accel_rdata), .accel_resp(accel_resp),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd),
    .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .timeout_flag(timeout_flag)
  );
`else
  scr1_dmem_accel_router dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .accel_req(accel_req), .accel_req_ack(accel_req_ack), .accel_cmd(accel_cmd),
    .accel_width(accel_width), .accel_addr(accel_addr), .accel_wdata(accel_wdata),
    .accel_rdata(accel_rdata), .accel_resp(accel_resp),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd),
    .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference routing: 0 = accelerator (32-byte window at F000_0000), 1 = memory (low 1 MiB), 2 = unmapped.
  function automatic int route(input logic [31:0] a);
    if (a >= 32'hF000_0000 && a <= 32'hF000_001F) return 0;
    if (a < 32'h0010_0000) return 1;
    return 2;
  endfunction

  function automatic type_scr1_mem_resp_e any_resp();
    case ($urandom_range(0, 2))
      0:       return SCR1_MEM_RESP_NOTRDY;
      1:       return SCR1_MEM_RESP_RDY_OK;
      default: return SCR1_MEM_RESP_RDY_ER;
    endcase
  endfunction

  function automatic type_scr1_mem_width_e any_width();
    case ($urandom_range(0, 2))
      0:       return SCR1_MEM_WIDTH_BYTE;
      1:       return SCR1_MEM_WIDTH_HWORD;
      default: return SCR1_MEM_WIDTH_WORD;
    endcase
  endfunction

  // Present a request; the owning target acks after ack_dly cycles, the other target acks randomly.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int ack_dly, output int tgt);
    int dly;
    tgt = route(addr);
    dly = (tgt == 2) ? 0 : ack_dly;
    @(negedge clk);
    core_req   = 1'b1;
    core_cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    core_width = any_width();
    core_addr  = addr;
    core_wdata = wd;
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) @(negedge clk);
      accel_resp    = any_resp();
      mem_resp      = any_resp();
      accel_rdata   = $urandom;
      mem_rdata     = $urandom;
      accel_req_ack = (tgt == 0) ? (i == dly) : 1'($urandom_range(0, 1));
      mem_req_ack   = (tgt == 1) ? (i == dly) : 1'($urandom_range(0, 1));
      #1;
      chk("accel_req", 32'(accel_req), 32'(tgt == 0));
      chk("mem_req", 32'(mem_req), 32'(tgt == 1));
      chk("req_ack", 32'(core_req_ack), 32'(i == dly));
      chk("idle_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("idle_rdata", core_rdata, 32'h0);
    end
    chk("fwd_addr", (tgt == 1) ? mem_addr : accel_addr, addr);
    chk("fwd_wdata", (tgt == 1) ? mem_wdata : accel_wdata, wd);
    chk("fwd_cmd", 32'((tgt == 1) ? mem_cmd : accel_cmd), 32'(wr));
    chk("fwd_width", 32'((tgt == 1) ? mem_width : accel_width), 32'(core_width));
  endtask

  // Owning target answers after `waits` NOTRDY cycles; noise on the core and the other target.
  task automatic finish_txn(input int tgt, input int waits, input type_scr1_mem_resp_e rsp,
                            input logic [31:0] rd);
    int n;
    type_scr1_mem_resp_e own_rsp;
    logic [31:0] own_rd;
    n = (tgt == 2) ? 0 : waits;
    for (int w = 0; w <= n; w++) begin
      @(negedge clk);
      core_req      = 1'($urandom_range(0, 1));
      core_addr     = $urandom;
      accel_req_ack = 1'($urandom_range(0, 1));
      mem_req_ack   = 1'($urandom_range(0, 1));
      accel_resp    = any_resp();
      mem_resp      = any_resp();
      accel_rdata   = $urandom;
      mem_rdata     = $urandom;
      own_rsp       = (w == n) ? rsp : SCR1_MEM_RESP_NOTRDY;
      own_rd        = (w == n) ? rd : $urandom;
      if (tgt == 0) begin accel_resp = own_rsp; accel_rdata = own_rd; end
      if (tgt == 1) begin mem_resp = own_rsp; mem_rdata = own_rd; end
      #1;
      chk("wait_req_ack", 32'(core_req_ack), 32'h0);
      chk("wait_accel_req", 32'(accel_req), 32'h0);
      chk("wait_mem_req", 32'(mem_req), 32'h0);
      chk("resp", 32'(core_resp), 32'((tgt == 2) ? SCR1_MEM_RESP_RDY_ER : own_rsp));
      chk("rdata", core_rdata, (tgt == 2) ? 32'h0 : own_rd);
    end
    core_req = 1'b0;
  endtask

  task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd, input int ack_dly,
                     input int waits, input type_scr1_mem_resp_e rsp, input logic [31:0] rd);
    int tgt;
    issue(addr, wr, wd, ack_dly, tgt);
    finish_txn(tgt, waits, rsp, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int tgt;
    logic [31:0] a, rd_exp;
    logic [31:0] edge_addrs [6];
    edge_addrs = '{32'hF000_001C, 32'hF000_0020, 32'hEFFF_FFFC, 32'h000F_FFFC, 32'h0010_0000, 32'hF000_0000};

    // Reset state with a live request and acking targets.
    rst_n = 1'b0; core_req = 1'b1; core_cmd = SCR1_MEM_CMD_WR; core_width = SCR1_MEM_WIDTH_WORD;
    core_addr = 32'hF000_0000; core_wdata = 32'h1234_5678;
    accel_req_ack = 1'b1; mem_req_ack = 1'b1; accel_rdata = 32'hAAAA_5555; mem_rdata = 32'h5555_AAAA;
    accel_resp = SCR1_MEM_RESP_RDY_OK; mem_resp = SCR1_MEM_RESP_RDY_OK;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_req_ack", 32'(core_req_ack), 32'h0);
      chk("rst_accel_req", 32'(accel_req), 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_rdata", core_rdata, 32'h0);
    end
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    chk("rst_timeout_flag", 32'(timeout_flag), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1; core_req = 1'b0;

    // Directed scenarios.
    txn(32'hF000_0008, 1'b1, 32'h0000_0005, 0, 0, SCR1_MEM_RESP_RDY_OK, 32'h0);
    txn(32'hF000_0010, 1'b0, 32'h0, 0, 0, SCR1_MEM_RESP_RDY_OK, 32'h0000_0019);
    txn(32'h0000_0100, 1'b0, 32'h0, 0, 3, SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF);
    txn(32'h0000_0104, 1'b1, 32'hCAFE_F00D, 0, 0, SCR1_MEM_RESP_RDY_ER, 32'h0);
    txn(32'h8000_0000, 1'b1, 32'h1111_2222, 0, 0, SCR1_MEM_RESP_RDY_OK, 32'h0);
    txn(32'hF000_0004, 1'b0, 32'h0, 2, 1, SCR1_MEM_RESP_RDY_ER, 32'h0BAD_0BAD);

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    // Memory never answers: error four cycles after acceptance, then sticky flag.
    issue(32'h0000_0200, 1'b0, 32'h0, 0, tgt);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      core_req = 1'b0; mem_resp = SCR1_MEM_RESP_NOTRDY; mem_rdata = $urandom | 32'h1;
      #1;
      chk("to_resp", 32'(core_resp), 32'((w == 3) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_NOTRDY));
      chk("to_rdata", core_rdata, (w == 3) ? 32'h0 : mem_rdata);
      chk("to_flag_pre", 32'(timeout_flag), 32'h0);
    end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      mem_resp = SCR1_MEM_RESP_RDY_OK;
      #1;
      chk("to_flag_post", 32'(timeout_flag), 32'h1);
      chk("to_idle_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    end
`endif

    // Reset during WAIT_MEM; the late memory response must be ignored.
    issue(32'h0000_0300, 1'b0, 32'h0, 0, tgt);
    @(negedge clk);
    rst_n = 1'b0; core_req = 1'b1; core_addr = 32'hF000_0000; accel_req_ack = 1'b1;
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    chk("mid_rst_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("mid_rst_req_ack", 32'(core_req_ack), 32'h0);
    chk("mid_rst_accel_req", 32'(accel_req), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; core_req = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h7777_7777;
    #1;
    chk("late_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("late_rdata", core_rdata, 32'h0);
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    chk("flag_cleared", 32'(timeout_flag), 32'h0);
`endif
    txn(32'h0000_0400, 1'b1, 32'h4444_4444, 1, 2, SCR1_MEM_RESP_RDY_OK, 32'h0);

    // Random traffic over windows, unmapped space and window edges.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'hF000_0000 + 32'($urandom_range(0, 31));
        1:       a = 32'($urandom_range(0, 32'h000F_FFFF));
        2:       a = $urandom;
        default: a = edge_addrs[$urandom_range(0, 5)];
      endcase
      rd_exp = $urandom;
      txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), $urandom_range(0, MaxWaits),
          ($urandom_range(0, 1) == 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER, rd_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
